ras_ckpt_stack: RTL and testbench

- Parametrised return-address stack (RAS) for the frontend branch predictor. It generalises the fixed-depth RAS to any depth, optional capability tag bits, circular overflow and checkpoint/restore for misprediction recovery.
- Sits between the branch-prediction decode logic (push on call, pop on return) and the next-PC selection.
- Depth is taken from the core's RAS depth configuration field.

---
 rtl/ras_ckpt_stack_if.sv | 31 +++
 rtl/ras_ckpt_stack.sv | 137 +++++++++++++
 tb/tb_ras_ckpt_stack.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ras_ckpt_stack_if.sv
// Predictor-side port bundle for the return-address stack.
// Master drives requests and reads the top-of-stack view.
interface ras_ckpt_stack_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int TAG_WIDTH  = 1
);
   logic                  flush_i;
   logic                  push_i;
   logic                  pop_i;
   logic [ADDR_WIDTH-1:0] data_i;
   logic [TAG_WIDTH-1:0]  tag_i;
   logic                  ckpt_i;
   logic                  restore_i;
   logic                  valid_o;
   logic [ADDR_WIDTH-1:0] ra_o;
   logic [TAG_WIDTH-1:0]  tag_o;
   logic                  overflow_o;
   logic                  underflow_o;

   modport master (
      output flush_i, push_i, pop_i, data_i, tag_i,
      output ckpt_i, restore_i,
      input  valid_o, ra_o, tag_o, overflow_o, underflow_o
   );

   modport slave (
      input  flush_i, push_i, pop_i, data_i, tag_i,
      input  ckpt_i, restore_i,
      output valid_o, ra_o, tag_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/ras_ckpt_stack.sv
// Circular return-address stack with top/count checkpoint and restore.
// Define RAS_CAP_TAG_EN to store a capability tag alongside each address.
module ras_ckpt_stack #(
   parameter int DEPTH      = 2,
   parameter int ADDR_WIDTH = 64,
   parameter int TAG_WIDTH  = 1
) (
   input logic             clk_i,
   input logic             rst_ni,
   ras_ckpt_stack_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] TOP_MAX = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   logic [PW-1:0] top_q, top_d;
   logic [PW-1:0] top_inc, top_dec;
   logic [PW-1:0] ckpt_top_q, ckpt_top_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] ckpt_cnt_q, ckpt_cnt_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          wr_en;
   logic [PW-1:0] wr_idx;
   logic          empty;
   logic          do_push, do_pop, do_repl;

   logic [ADDR_WIDTH-1:0] ra_mem_q [DEPTH];

   always_comb begin
      top_inc = (top_q == TOP_MAX) ? '0 : top_q + 1'b1;
      top_dec = (top_q == '0) ? TOP_MAX : top_q - 1'b1;
   end

   // Push+pop on an empty stack degrades to a plain push.
   assign empty   = (cnt_q == '0);
   assign do_push = bus.push_i & (~bus.pop_i | empty);
   assign do_repl = bus.push_i & bus.pop_i & ~empty;
   assign do_pop  = bus.pop_i & ~bus.push_i;

   always_comb begin
      top_d  = top_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_idx = top_q;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
      if (bus.flush_i) begin
         cnt_d = '0;
      end else if (bus.restore_i) begin
         top_d = ckpt_top_q;
         cnt_d = ckpt_cnt_q;
      end else if (do_push) begin
         top_d  = top_inc;
         wr_en  = 1'b1;
         wr_idx = top_inc;
         if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (do_repl) begin
         wr_en = 1'b1;
      end else if (do_pop) begin
         if (empty) begin
            udf_d = 1'b1;
         end else begin
            top_d = top_dec;
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Snapshot follows the post-update state of the same cycle.
   always_comb begin
      ckpt_top_d = ckpt_top_q;
      ckpt_cnt_d = ckpt_cnt_q;
      if (bus.ckpt_i && !bus.flush_i) begin
         ckpt_top_d = top_d;
         ckpt_cnt_d = cnt_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         top_q      <= '0;
         cnt_q      <= '0;
         ckpt_top_q <= '0;
         ckpt_cnt_q <= '0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         top_q      <= top_d;
         cnt_q      <= cnt_d;
         ckpt_top_q <= ckpt_top_d;
         ckpt_cnt_q <= ckpt_cnt_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            ra_mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         ra_mem_q[wr_idx] <= bus.data_i;
      end
   end

`ifdef RAS_CAP_TAG_EN
   logic [TAG_WIDTH-1:0] tag_mem_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            tag_mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         tag_mem_q[wr_idx] <= bus.tag_i;
      end
   end

   assign bus.tag_o = tag_mem_q[top_q];
`else
   logic unused_tag;
   assign unused_tag = ^bus.tag_i;
   assign bus.tag_o  = '0;
`endif

   assign bus.valid_o     = ~empty;
   assign bus.ra_o        = ra_mem_q[top_q];
   assign bus.overflow_o  = ovf_q;
   assign bus.underflow_o = udf_q;
endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Scoreboard bench: DEPTH=2 and DEPTH=4 stacks driven in lockstep
// against an array-based stack model.
module tb_ras_ckpt_stack;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush, push, pop, ckpt, restore;
   logic [63:0] data;
   logic        tag;

   int checks = 0;
   int errors = 0;

   ras_ckpt_stack_if #(.ADDR_WIDTH(64), .TAG_WIDTH(1)) bus2 ();
   ras_ckpt_stack_if #(.ADDR_WIDTH(64), .TAG_WIDTH(1)) bus4 ();

   assign bus2.flush_i   = flush;
   assign bus2.push_i    = push;
   assign bus2.pop_i     = pop;
   assign bus2.data_i    = data;
   assign bus2.tag_i     = tag;
   assign bus2.ckpt_i    = ckpt;
   assign bus2.restore_i = restore;
   assign bus4.flush_i   = flush;
   assign bus4.push_i    = push;
   assign bus4.pop_i     = pop;
   assign bus4.data_i    = data;
   assign bus4.tag_i     = tag;
   assign bus4.ckpt_i    = ckpt;
   assign bus4.restore_i = restore;

   ras_ckpt_stack #(.DEPTH(2), .ADDR_WIDTH(64), .TAG_WIDTH(1)) u_d2 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus2.slave)
   );

   ras_ckpt_stack #(.DEPTH(4), .ADDR_WIDTH(64), .TAG_WIDTH(1)) u_d4 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus4.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          k;
      logic        v;
      logic [63:0] ra;
      logic        tg;
      logic        ovf;
      logic        udf;
   } exp_t;

   exp_t sb[$];

   // Reference stack: plain arrays with modulo pointer arithmetic.
   int          depth [2];
   logic [63:0] m_ra  [2][64];
   logic        m_tag [2][64];
   int          m_top [2];
   int          m_cnt [2];
   int          m_ct  [2];
   int          m_cc  [2];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 64; i++) begin
            m_ra[k][i]  = '0;
            m_tag[k][i] = 1'b0;
         end
         m_top[k] = 0;
         m_cnt[k] = 0;
         m_ct[k]  = 0;
         m_cc[k]  = 0;
      end
   endtask

   task automatic model_update(input int k);
      int   d;
      logic ov, un;
      exp_t e;
      d  = depth[k];
      ov = 1'b0;
      un = 1'b0;
      if (flush) begin
         m_cnt[k] = 0;
      end else if (restore) begin
         m_top[k] = m_ct[k];
         m_cnt[k] = m_cc[k];
      end else if (push && pop && m_cnt[k] > 0) begin
         m_ra[k][m_top[k]]  = data;
         m_tag[k][m_top[k]] = tag;
      end else if (push) begin
         m_top[k] = (m_top[k] + 1) % d;
         m_ra[k][m_top[k]]  = data;
         m_tag[k][m_top[k]] = tag;
         if (m_cnt[k] == d) ov = 1'b1;
         else m_cnt[k]++;
      end else if (pop) begin
         if (m_cnt[k] == 0) un = 1'b1;
         else begin
            m_top[k] = (m_top[k] + d - 1) % d;
            m_cnt[k]--;
         end
      end
      if (ckpt && !flush) begin
         m_ct[k] = m_top[k];
         m_cc[k] = m_cnt[k];
      end
      e.k   = k;
      e.v   = (m_cnt[k] != 0);
      e.ra  = m_ra[k][m_top[k]];
`ifdef RAS_CAP_TAG_EN
      e.tg  = m_tag[k][m_top[k]];
`else
      e.tg  = 1'b0;
`endif
      e.ovf = ov;
      e.udf = un;
      sb.push_back(e);
   endtask

   task automatic step(input logic f, input logic pu, input logic po,
                       input logic [63:0] d, input logic tg,
                       input logic ck, input logic rs);
      flush   = f;
      push    = pu;
      pop     = po;
      data    = d;
      tag     = tg;
      ckpt    = ck;
      restore = rs;
      @(posedge clk);
      model_update(0);
      model_update(1);
      #1;
      flush   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      ckpt    = 1'b0;
      restore = 1'b0;
   endtask

   task automatic idle();
      step(0, 0, 0, 64'h0, 0, 0, 0);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_v2"}, 64'(bus2.valid_o), 64'h0);
      chk({nm, "_ra2"}, bus2.ra_o, 64'h0);
      chk({nm, "_tg2"}, 64'(bus2.tag_o), 64'h0);
      chk({nm, "_ov2"}, 64'(bus2.overflow_o), 64'h0);
      chk({nm, "_un2"}, 64'(bus2.underflow_o), 64'h0);
      chk({nm, "_v4"}, 64'(bus4.valid_o), 64'h0);
      chk({nm, "_ra4"}, bus4.ra_o, 64'h0);
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      while (sb.size() != 0) begin
         mon_e = sb.pop_front();
         if (mon_e.k == 0) begin
            chk("sb_valid2", 64'(bus2.valid_o), 64'(mon_e.v));
            chk("sb_ra2", bus2.ra_o, mon_e.ra);
            chk("sb_tag2", 64'(bus2.tag_o), 64'(mon_e.tg));
            chk("sb_ovf2", 64'(bus2.overflow_o), 64'(mon_e.ovf));
            chk("sb_udf2", 64'(bus2.underflow_o), 64'(mon_e.udf));
         end else begin
            chk("sb_valid4", 64'(bus4.valid_o), 64'(mon_e.v));
            chk("sb_ra4", bus4.ra_o, mon_e.ra);
            chk("sb_tag4", 64'(bus4.tag_o), 64'(mon_e.tg));
            chk("sb_ovf4", 64'(bus4.overflow_o), 64'(mon_e.ovf));
            chk("sb_udf4", 64'(bus4.underflow_o), 64'(mon_e.udf));
         end
      end
   end

   initial begin
      depth[0] = 2;
      depth[1] = 4;
      model_reset();
      flush = 0; push = 0; pop = 0; ckpt = 0; restore = 0;
      data = '0; tag = 0;
      #2;
      chk_zero("reset");
      #1 rst_n = 1'b1;

      // basic push/pop
      step(0, 1, 0, 64'h1000, 0, 0, 0);
      step(0, 1, 0, 64'h2000, 0, 0, 0);
      chk("tp1_valid", 64'(bus2.valid_o), 64'h1);
      chk("tp1_ra", bus2.ra_o, 64'h2000);
      step(0, 0, 1, 64'h0, 0, 0, 0);
      chk("tp1_pop_ra", bus2.ra_o, 64'h1000);
      step(0, 0, 1, 64'h0, 0, 0, 0);
      chk("tp1_empty", 64'(bus2.valid_o), 64'h0);

      // overflow on depth 2
      step(1, 0, 0, 64'h0, 0, 0, 0);
      step(0, 1, 0, 64'hA0, 0, 0, 0);
      step(0, 1, 0, 64'hB0, 0, 0, 0);
      chk("tp2_no_ovf", 64'(bus2.overflow_o), 64'h0);
      step(0, 1, 0, 64'hC0, 0, 0, 0);
      chk("tp2_ovf", 64'(bus2.overflow_o), 64'h1);
      step(0, 0, 1, 64'h0, 0, 0, 0);
      chk("tp2_ovf_clr", 64'(bus2.overflow_o), 64'h0);
      chk("tp2_ra", bus2.ra_o, 64'hB0);
      step(0, 0, 1, 64'h0, 0, 0, 0);
      chk("tp2_lost", 64'(bus2.valid_o), 64'h0);

      // underflow, then push+pop on empty
      step(0, 0, 1, 64'h0, 0, 0, 0);
      chk("tp3_udf", 64'(bus2.underflow_o), 64'h1);
      chk("tp3_v", 64'(bus2.valid_o), 64'h0);
      step(0, 1, 1, 64'h40, 0, 0, 0);
      chk("tp3_udf_clr", 64'(bus2.underflow_o), 64'h0);
      chk("tp3_ra", bus2.ra_o, 64'h40);
      chk("tp3_v1", 64'(bus2.valid_o), 64'h1);

      // checkpoint / restore on depth 4
      step(1, 0, 0, 64'h0, 0, 0, 0);
      step(0, 1, 0, 64'h10, 0, 0, 0);
      step(0, 1, 0, 64'h20, 0, 0, 0);
      step(0, 0, 0, 64'h0, 0, 1, 0);
      step(0, 0, 1, 64'h0, 0, 0, 0);
      step(0, 0, 1, 64'h0, 0, 0, 0);
      step(0, 1, 0, 64'h30, 0, 0, 0);
      step(0, 0, 0, 64'h0, 0, 0, 1);
      chk("tp4_v", 64'(bus4.valid_o), 64'h1);
      chk("tp4_ra", bus4.ra_o, 64'h20);
      step(0, 0, 1, 64'h0, 0, 0, 0);

      // flush dominates push and restore
      step(1, 1, 0, 64'h77, 0, 0, 1);
      chk("tp5_v", 64'(bus4.valid_o), 64'h0);
      chk("tp5_ov", 64'(bus4.overflow_o), 64'h0);
      step(0, 1, 0, 64'h50, 0, 0, 0);
      chk("tp5_ra", bus4.ra_o, 64'h50);

      // tags
      step(0, 1, 0, 64'h80, 1, 0, 0);
      step(0, 1, 0, 64'h90, 0, 0, 0);
      chk("tp6_tag0", 64'(bus4.tag_o), 64'h0);
      step(0, 0, 1, 64'h0, 0, 0, 0);
`ifdef RAS_CAP_TAG_EN
      chk("tp6_tag1", 64'(bus4.tag_o), 64'h1);
`else
      chk("tp6_tag1", 64'(bus4.tag_o), 64'h0);
`endif

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         step(($urandom % 16) == 0, $urandom % 2, $urandom % 2,
              {$urandom, $urandom}, $urandom % 2,
              ($urandom % 6) == 0, ($urandom % 8) == 0);
      end

      // asynchronous reset in the middle of a push
      @(negedge clk);
      #1;
      push = 1'b1;
      data = 64'hDEAD;
      tag  = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      push = 1'b0;
      model_reset();
      #1 rst_n = 1'b1;

      for (int n = 0; n < 100; n++) begin
         step(($urandom % 16) == 0, $urandom % 2, $urandom % 2,
              {$urandom, $urandom}, $urandom % 2,
              ($urandom % 6) == 0, ($urandom % 8) == 0);
      end
      idle();
      @(negedge clk);
      #1;
      chk("sb_drained", 64'(sb.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
